// File: rtl/x_23k640_req_queue.sv
// Request/completion buffer in front of the 23K640 SPI data engine.
// Presents the head request to the engine and collects read data, issuing reads only with completion credit.
module x_23k640_req_queue #(
    parameter int REQ_DEPTH = 4,
    parameter int CPL_DEPTH = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_req_valid,
    output logic                           o_req_ready,
    input  logic                           i_req_rd_n_wr,
    input  logic [15:0]                    i_req_addr,
    input  logic [7:0]                     i_req_wdata,
    output logic                           o_cpl_valid,
    input  logic                           i_cpl_ready,
    output logic [7:0]                     o_cpl_rdata,
    output logic                           o_valid,
    input  logic                           i_accept,
    output logic                           o_rd_n_wr,
    output logic [15:0]                    o_addr,
    output logic [7:0]                     o_wdata,
    input  logic                           i_ready,
    input  logic [7:0]                     i_rdata,
    output logic [$clog2(REQ_DEPTH+1)-1:0] o_req_count,
    output logic                           o_err
);

    localparam int RAW = $clog2(REQ_DEPTH);
    localparam int RCW = $clog2(REQ_DEPTH + 1);
    localparam int CAW = $clog2(CPL_DEPTH);
    localparam int CCW = $clog2(CPL_DEPTH + 1);

    // Handshakes: a transfer happens on a clock edge where valid and ready/accept are both high;
    // valid, once raised, stays high with its payload stable until that transfer.

    logic [15:0]    req_addr_mem  [REQ_DEPTH];
    logic [7:0]     req_wdata_mem [REQ_DEPTH];
    logic           req_rd_mem    [REQ_DEPTH];
    logic [RAW-1:0] req_wr_ptr;
    logic [RAW-1:0] req_rd_ptr;
    logic [RCW-1:0] req_count;

    logic [7:0]     cpl_mem [CPL_DEPTH];
    logic [CAW-1:0] cpl_wr_ptr;
    logic [CAW-1:0] cpl_rd_ptr;
    logic [CCW-1:0] cpl_count;
    logic [CCW-1:0] outstanding;
    logic           err;

    logic           req_full;
    logic           req_empty;
    logic           req_push;
    logic           req_pop;
    logic           head_rd;
    logic           cpl_full;
    logic           cpl_empty;
    logic           cpl_push;
    logic           cpl_pop;
    logic           read_inc;
    logic           err_event;
    logic [CCW:0]   credit_sum;
    logic           credit_ok;

    assign req_full  = (req_count == RCW'(REQ_DEPTH));
    assign req_empty = (req_count == '0);
    assign req_push  = i_req_valid & ~req_full;
    assign req_pop   = i_accept & ~req_empty;
    assign head_rd   = req_rd_mem[req_rd_ptr];

    assign cpl_full  = (cpl_count == CCW'(CPL_DEPTH));
    assign cpl_empty = (cpl_count == '0);
    assign cpl_push  = i_ready & (outstanding != '0) & ~cpl_full;
    assign cpl_pop   = ~cpl_empty & i_cpl_ready;
    assign read_inc  = req_pop & head_rd;

    // One extra bit so outstanding + buffered can never wrap in the compare.
    assign credit_sum = {1'b0, outstanding} + {1'b0, cpl_count};
    assign credit_ok  = credit_sum < (CCW + 1)'(CPL_DEPTH);

    assign err_event = (i_accept & req_empty)
                     | (i_ready & (outstanding == '0))
                     | (i_ready & cpl_full);

    assign o_req_ready = ~req_full;
    assign o_req_count = req_count;
    assign o_valid     = ~req_empty & (~head_rd | credit_ok);
    assign o_addr      = req_addr_mem[req_rd_ptr];
    assign o_wdata     = req_wdata_mem[req_rd_ptr];
    assign o_rd_n_wr   = head_rd;
    assign o_cpl_valid = ~cpl_empty;
    assign o_cpl_rdata = cpl_mem[cpl_rd_ptr];
    assign o_err       = err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < REQ_DEPTH; i++) begin
                req_addr_mem[i]  <= '0;
                req_wdata_mem[i] <= '0;
                req_rd_mem[i]    <= 1'b0;
            end
            req_wr_ptr <= '0;
            req_rd_ptr <= '0;
            req_count  <= '0;
        end else begin
            if (req_push) begin
                req_addr_mem[req_wr_ptr]  <= i_req_addr;
                req_wdata_mem[req_wr_ptr] <= i_req_wdata;
                req_rd_mem[req_wr_ptr]    <= i_req_rd_n_wr;
                req_wr_ptr                <= req_wr_ptr + 1'b1;
            end
            if (req_pop) begin
                req_rd_ptr <= req_rd_ptr + 1'b1;
            end
            case ({req_push, req_pop})
                2'b10:   req_count <= req_count + 1'b1;
                2'b01:   req_count <= req_count - 1'b1;
                default: req_count <= req_count;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < CPL_DEPTH; i++) begin
                cpl_mem[i] <= '0;
            end
            cpl_wr_ptr <= '0;
            cpl_rd_ptr <= '0;
            cpl_count  <= '0;
        end else begin
            if (cpl_push) begin
                cpl_mem[cpl_wr_ptr] <= i_rdata;
                cpl_wr_ptr          <= cpl_wr_ptr + 1'b1;
            end
            if (cpl_pop) begin
                cpl_rd_ptr <= cpl_rd_ptr + 1'b1;
            end
            case ({cpl_push, cpl_pop})
                2'b10:   cpl_count <= cpl_count + 1'b1;
                2'b01:   cpl_count <= cpl_count - 1'b1;
                default: cpl_count <= cpl_count;
            endcase
        end
    end

    // Reads in flight inside the engine; together with cpl_count this is the credit in use.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            outstanding <= '0;
            err         <= 1'b0;
        end else begin
            case ({read_inc, cpl_push})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (err_event) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_x_23k640_req_queue.sv
// Directed bench for x_23k640_req_queue: hand-computed expectations for each queue scenario.
`timescale 1ns/1ps
module tb_x_23k640_req_queue;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_rd_n_wr = 1'b0;
    logic [15:0] i_req_addr = '0;
    logic [7:0]  i_req_wdata = '0;
    logic        o_cpl_valid;
    logic        i_cpl_ready = 1'b0;
    logic [7:0]  o_cpl_rdata;
    logic        o_valid;
    logic        i_accept = 1'b0;
    logic        o_rd_n_wr;
    logic [15:0] o_addr;
    logic [7:0]  o_wdata;
    logic        i_ready = 1'b0;
    logic [7:0]  i_rdata = '0;
    logic [2:0]  o_req_count;
    logic        o_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic hold_pending = 1'b0;

    x_23k640_req_queue #(.REQ_DEPTH(4), .CPL_DEPTH(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_rd_n_wr(i_req_rd_n_wr), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_cpl_valid(o_cpl_valid), .i_cpl_ready(i_cpl_ready), .o_cpl_rdata(o_cpl_rdata),
        .o_valid(o_valid), .i_accept(i_accept), .o_rd_n_wr(o_rd_n_wr),
        .o_addr(o_addr), .o_wdata(o_wdata), .i_ready(i_ready), .i_rdata(i_rdata),
        .o_req_count(o_req_count), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic rd, input logic [15:0] addr, input logic [7:0] wdata);
        i_req_valid = 1'b1; i_req_rd_n_wr = rd; i_req_addr = addr; i_req_wdata = wdata;
        tick();
        i_req_valid = 1'b0;
    endtask

    task automatic accept_pulse();
        i_accept = 1'b1;
        tick();
        i_accept = 1'b0;
    endtask

    task automatic ready_pulse(input logic [7:0] d);
        i_ready = 1'b1; i_rdata = d;
        tick();
        i_ready = 1'b0;
    endtask

    task automatic cpl_pop();
        i_cpl_ready = 1'b1;
        tick();
        i_cpl_ready = 1'b0;
    endtask

    // A raised o_valid must survive every edge without an accept.
    always @(posedge i_clk) hold_pending <= o_valid && !i_accept && !i_rst;
    always @(negedge i_clk) begin
        if (hold_pending && !i_rst) check("valid_hold", o_valid, 1);
    end

    initial begin
        tick(); tick();
        i_rst = 1'b0;
        tick();
        check("rst_req_ready", o_req_ready, 1);
        check("rst_valid", o_valid, 0);
        check("rst_cpl_valid", o_cpl_valid, 0);
        check("rst_count", o_req_count, 0);
        check("rst_addr", o_addr, 0);
        check("rst_wdata", o_wdata, 0);
        check("rst_rd_n_wr", o_rd_n_wr, 0);
        check("rst_cpl_rdata", o_cpl_rdata, 0);
        check("rst_err", o_err, 0);

        // Single write
        push(1'b0, 16'h0123, 8'hA5);
        check("wr_valid", o_valid, 1);
        check("wr_addr", o_addr, 16'h0123);
        check("wr_wdata", o_wdata, 8'hA5);
        check("wr_rd_n_wr", o_rd_n_wr, 0);
        check("wr_count", o_req_count, 1);
        tick(); tick();
        check("wr_held_addr", o_addr, 16'h0123);
        accept_pulse();
        check("wr_done_valid", o_valid, 0);
        check("wr_done_count", o_req_count, 0);

        // Single read
        push(1'b1, 16'h1FFF, 8'h00);
        check("rd_valid", o_valid, 1);
        check("rd_rd_n_wr", o_rd_n_wr, 1);
        check("rd_addr", o_addr, 16'h1FFF);
        accept_pulse();
        check("rd_acc_valid", o_valid, 0);
        ready_pulse(8'h3C);
        check("rd_cpl_valid", o_cpl_valid, 1);
        check("rd_cpl_rdata", o_cpl_rdata, 8'h3C);
        cpl_pop();
        check("rd_idle_cpl", o_cpl_valid, 0);
        check("rd_idle_err", o_err, 0);

        // Full request FIFO, refused push, order across wrap
        for (int i = 0; i < 4; i++) push(1'b0, 16'h0100 + 16'(i), 8'h10 + 8'(i));
        check("full_ready", o_req_ready, 0);
        check("full_count", o_req_count, 4);
        push(1'b0, 16'h01FF, 8'hFF);
        check("full_refused_count", o_req_count, 4);
        accept_pulse();
        check("full_reopen_ready", o_req_ready, 1);
        check("full_reopen_count", o_req_count, 3);
        for (int i = 1; i < 8; i++) begin
            check("wrap_addr", o_addr, 16'h0100 + 16'(i));
            check("wrap_wdata", o_wdata, 8'h10 + 8'(i));
            if (i + 3 <= 7) begin
                i_req_valid = 1'b1; i_req_rd_n_wr = 1'b0;
                i_req_addr = 16'h0100 + 16'(i + 3); i_req_wdata = 8'h10 + 8'(i + 3);
                i_accept = 1'b1;
                tick();
                i_req_valid = 1'b0; i_accept = 1'b0;
                check("wrap_pushpop_count", o_req_count, 3);
            end else begin
                accept_pulse();
            end
        end
        check("wrap_empty_count", o_req_count, 0);

        // Completion backpressure
        for (int k = 0; k < 4; k++) begin
            push(1'b1, 16'h0200 + 16'(k), 8'h00);
            accept_pulse();
            ready_pulse(8'hC0 + 8'(k));
        end
        push(1'b0, 16'h0250, 8'h77);
        push(1'b1, 16'h0300, 8'h00);
        check("bp_write_issues", o_valid, 1);
        accept_pulse();
        check("bp_read_gated", o_valid, 0);
        check("bp_gated_count", o_req_count, 1);
        check("bp_head_c0", o_cpl_rdata, 8'hC0);
        cpl_pop();
        check("bp_credit_valid", o_valid, 1);
        check("bp_head_c1", o_cpl_rdata, 8'hC1);

        // Accept of a read together with i_ready
        accept_pulse();
        check("sim_acc_valid", o_valid, 0);
        cpl_pop();
        push(1'b1, 16'h0301, 8'h00);
        check("sim_rd_valid", o_valid, 1);
        i_accept = 1'b1; i_ready = 1'b1; i_rdata = 8'hD0;
        tick();
        i_accept = 1'b0; i_ready = 1'b0;
        push(1'b1, 16'h0302, 8'h00);
        check("sim_out_gated", o_valid, 0);
        check("sim_head_c2", o_cpl_rdata, 8'hC2);
        cpl_pop();
        check("sim_out_credit", o_valid, 1);
        check("sim_head_c3", o_cpl_rdata, 8'hC3);

        // Push and pop on both FIFOs in one cycle
        i_req_valid = 1'b1; i_req_rd_n_wr = 1'b0; i_req_addr = 16'h0400; i_req_wdata = 8'h99;
        i_accept = 1'b1; i_ready = 1'b1; i_rdata = 8'hD1; i_cpl_ready = 1'b1;
        tick();
        i_req_valid = 1'b0; i_accept = 1'b0; i_ready = 1'b0; i_cpl_ready = 1'b0;
        check("both_req_count", o_req_count, 1);
        check("both_addr", o_addr, 16'h0400);
        check("both_wdata", o_wdata, 8'h99);
        check("both_rd_n_wr", o_rd_n_wr, 0);
        check("both_cpl_d0", o_cpl_rdata, 8'hD0);
        cpl_pop();
        check("both_cpl_d1", o_cpl_rdata, 8'hD1);
        cpl_pop();
        check("both_cpl_empty", o_cpl_valid, 0);
        ready_pulse(8'hD2);
        check("both_cpl_d2", o_cpl_rdata, 8'hD2);
        accept_pulse();
        cpl_pop();
        check("idle_count", o_req_count, 0);
        check("idle_cpl", o_cpl_valid, 0);
        check("idle_err", o_err, 0);

        // Errors and asynchronous reset
        accept_pulse();
        check("err_acc_empty", o_err, 1);
        check("err_acc_count", o_req_count, 0);
        check("err_acc_valid", o_valid, 0);
        push(1'b0, 16'h0500, 8'h01);
        push(1'b0, 16'h0501, 8'h02);
        check("mid_count", o_req_count, 2);
        i_rst = 1'b1;
        #1;
        check("arst_err", o_err, 0);
        check("arst_count", o_req_count, 0);
        check("arst_valid", o_valid, 0);
        check("arst_addr", o_addr, 0);
        tick();
        i_rst = 1'b0;
        tick();
        ready_pulse(8'h55);
        check("err_ready_idle", o_err, 1);
        check("err_ready_cpl", o_cpl_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
